mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter and access sequencer for the shared 8-word × 16-bit unified memory of the 3-stage processor. It multiplexes instruction-fetch reads and data load/store accesses onto the single memory port, registering address, write-data and write-enable for a full cycle, capturing read data, and returning per-port responses. Data accesses have priority; a starvation guard bounds fetch wait time.

## Interface
- DEPTH, 8: number of implemented memory words; addresses >= DEPTH are out of range.
- STARVE_LIMIT, 4: consecutive data wins over a pending fetch before fetch is forced (range 1–15).
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  8  fetch address; stable while if_req high.
- if_gnt  out  1  one-cycle fetch accept pulse.
- if_valid  out  1  one-cycle fetch response pulse.
- if_rdata  out  16  fetch read data; holds until next fetch response.
- if_err  out  1  qualifies if_valid: address out of range.
- dm_req  in  1  data request; held until dm_gnt.
- dm_we  in  1  1 = store, 0 = load; stable with dm_req.
- dm_addr  in  8  data address.
- dm_wdata  in  16  store data.
- dm_gnt / dm_valid / dm_rdata[15:0] / dm_err  out  same as fetch counterparts.
- mem_addr  out  8  memory address.
- mem_din  out  16  memory write data.
- mem_we  out  1  memory write enable.
- mem_dout  in  16  memory read data (combinational from mem_addr).
- busy  out  1  high while state is ACCESS.

## Operation
- Clock is clk; reset is rst, asynchronous, active-high.
- States: IDLE, ACCESS. Reset -> IDLE.
- IDLE, no request: stay; all pulse outputs 0.
- IDLE, request(s) sampled at clock edge: select winner, register gnt=1 for winner, latch mem_addr/mem_din/mem_we and winner id, go ACCESS.
- Selection: dm_req alone -> data; if_req alone -> fetch; both -> data unless starve_cnt == STARVE_LIMIT, then fetch.
- starve_cnt (4 bits): +1 when both pending and data wins; cleared when fetch wins or if_req low at a sample; never exceeds STARVE_LIMIT.
- Fetch grant always drives mem_we=0, mem_din unchanged.
- Out-of-range (addr >= DEPTH): grant still issued; mem_we forced 0, mem_addr not updated; response rdata = 16'hFFFF, err=1.
- ACCESS: at edge, capture mem_dout (or 16'hFFFF if out of range) into winner's rdata, pulse winner's valid (and err), clear mem_we, gnt=0, go IDLE. Requests during ACCESS ignored.
- Loads/fetches return mem_dout of the latched address; stores return the written value (memory reads back din) with err=0.
- Requester drops req in the cycle gnt is seen; req still high in the IDLE cycle after valid is a new request.
- Reset values: if_gnt, dm_gnt, if_valid, dm_valid, if_err, dm_err, mem_we, busy = 0; if_rdata, dm_rdata, mem_din = 16'h0000; mem_addr = 8'h00; starve_cnt = 0.
- Reset mid-ACCESS: all outputs to reset values immediately, no response issued. Store is committed once mem_we rose; it is not rolled back.

## Timing
- Edge E0 samples req in IDLE -> gnt, mem_* valid during cycle C1 (busy=1).
- Edge E1 -> valid/rdata/err valid during C2; state IDLE in C2.
- Latency req-sample to valid: 2 cycles; max throughput one access per 2 cycles.
- mem_we high exactly one cycle (C1) per in-range store; never high in IDLE.
- gnt and valid never high in the same cycle for the same port; at most one port granted per access.
- Worst-case fetch wait with continuous data traffic: STARVE_LIMIT accesses (2·STARVE_LIMIT cycles) after becoming pending.

## Test plan
- Reset, then fetch addr 8'h01 -> if_gnt at C1, if_valid at C2 with if_rdata=16'h1024, if_err=0; mem_we stays 0.
- Store dm_addr 8'h03, dm_wdata 16'hABCD, then load 8'h03 -> mem_we one cycle; load returns dm_rdata=16'hABCD.
- Simultaneous if_req (8'h00) and dm_req load (8'h02) -> dm granted first (16'h5005), fetch next access (16'h007D).
- if_req held high with back-to-back dm_req, STARVE_LIMIT=4 -> 4 data grants, then fetch granted on 5th access; starve_cnt returns to 0.
- dm store to 8'h09 -> no mem_we, dm_valid with dm_err=1, dm_rdata=16'hFFFF; memory 8'h01 still 16'h1024.
- Assert rst during ACCESS of a store -> all outputs 0 immediately, no dm_valid; after release, load same address returns new data.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter and access sequencer for the shared unified memory
module mem_arbiter #(
    parameter int DEPTH        = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [7:0]  if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [15:0] if_rdata,
    output logic        if_err,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [7:0]  dm_addr,
    input  logic [15:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_valid,
    output logic [15:0] dm_rdata,
    output logic        dm_err,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_din,
    output logic        mem_we,
    input  logic [15:0] mem_dout,
    output logic        busy
);

    localparam logic [8:0] DEPTH_W = 9'(DEPTH);
    localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state;
    logic [3:0]  starve_cnt;
    logic        win_dm;
    logic        oor;
    logic        pick_dm;
    logic [7:0]  sel_addr;
    logic        sel_oor;
    logic [15:0] rd_value;

    // Data wins ties unless the pending fetch has already lost LIMIT times in a row.
    always_comb begin
        pick_dm  = dm_req && !(if_req && starve_cnt == LIMIT);
        sel_addr = pick_dm ? dm_addr : if_addr;
        sel_oor  = {1'b0, sel_addr} >= DEPTH_W;
        rd_value = oor ? 16'hFFFF : mem_dout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            win_dm     <= 1'b0;
            oor        <= 1'b0;
            if_gnt     <= 1'b0;
            if_valid   <= 1'b0;
            if_rdata   <= 16'h0000;
            if_err     <= 1'b0;
            dm_gnt     <= 1'b0;
            dm_valid   <= 1'b0;
            dm_rdata   <= 16'h0000;
            dm_err     <= 1'b0;
            mem_addr   <= 8'h00;
            mem_din    <= 16'h0000;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if_gnt   <= 1'b0;
            dm_gnt   <= 1'b0;
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            if_err   <= 1'b0;
            dm_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        state  <= ACCESS;
                        busy   <= 1'b1;
                        win_dm <= pick_dm;
                        oor    <= sel_oor;
                        if (pick_dm) dm_gnt <= 1'b1;
                        else         if_gnt <= 1'b1;
                        // Out-of-range accesses leave the memory port address untouched.
                        if (!sel_oor) mem_addr <= sel_addr;
                        if (pick_dm)  mem_din  <= dm_wdata;
                        mem_we <= pick_dm && dm_we && !sel_oor;
                        if (pick_dm && if_req) starve_cnt <= starve_cnt + 4'd1;
                        else                   starve_cnt <= 4'd0;
                    end else begin
                        starve_cnt <= 4'd0;
                    end
                end
                ACCESS: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    mem_we <= 1'b0;
                    if (win_dm) begin
                        dm_valid <= 1'b1;
                        dm_err   <= oor;
                        dm_rdata <= rd_value;
                    end else begin
                        if_valid <= 1'b1;
                        if_err   <= oor;
                        if_rdata <= rd_value;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
